gate_event_logger: RTL and testbench

GATE_EVENT_LOGGER -- requirements
Module: gate_event_logger

---
 rtl/gate_event_logger.sv | 98 +++++++++
 tb/tb_gate_event_logger.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/gate_event_logger.sv
// gate_event_logger: logs changes of gate outputs c/d as timestamped records in a FIFO.
// Optional a/b consistency checker enabled by defining GATE_CHECK_EN.
module gate_event_logger #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [7:0]  ev_data,
    output logic [15:0] ev_count,
    output logic        overflow,
    output logic        mismatch
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t      state_q, state_d;
    logic        prev_c_q, prev_c_d, prev_d_q, prev_d_d;
    logic [3:0]  ts_q, ts_d;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [15:0] ev_count_q, ev_count_d;
    logic        overflow_q, overflow_d;
    logic        mismatch_q, mismatch_d;
    logic        event_w, push, pop, full, empty;
    logic [7:0]  rec;

    always_comb begin
        state_d = RUN;
        prev_c_d = c;
        prev_d_d = d;
        event_w = (state_q == RUN) && ((c ^ prev_c_q) || (d ^ prev_d_q));
        rec = {ts_q, c, d, c ^ prev_c_q, d ^ prev_d_q};
        ts_d = (state_q == INIT || event_w) ? 4'd0 : (ts_q == 4'hF ? ts_q : ts_q + 4'd1);
        empty = cnt_q == '0;
        full = cnt_q == FULL_CNT;
        // a full FIFO still accepts a push when the head leaves in the same cycle
        pop = !empty && ev_ready;
        push = event_w && (!full || pop);
        mem_d = mem_q;
        if (push) mem_d[wr_q] = rec;
        wr_d = push ? wr_q + AW'(1) : wr_q;
        rd_d = pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
        ev_count_d = ev_count_q + 16'(event_w);
        overflow_d = overflow_q | (event_w & full & !pop);
    end

`ifdef GATE_CHECK_EN
    always_comb mismatch_d = mismatch_q | ((state_q == RUN) && ((c != (a & b)) || (d != (a | b))));
`else
    logic unused_ab;
    assign unused_ab = a ^ b;
    always_comb mismatch_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            state_q    <= INIT;
            prev_c_q   <= 1'b0;
            prev_d_q   <= 1'b0;
            ts_q       <= 4'd0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            ev_count_q <= 16'd0;
            overflow_q <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_c_q   <= prev_c_d;
            prev_d_q   <= prev_d_d;
            ts_q       <= ts_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            ev_count_q <= ev_count_d;
            overflow_q <= overflow_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign ev_valid = !empty;
    assign ev_data  = empty ? 8'h00 : mem_q[rd_q];
    assign ev_count = ev_count_q;
    assign overflow = overflow_q;
    assign mismatch = mismatch_q;
endmodule

// File: tb/tb_gate_event_logger.sv
// tb_gate_event_logger: vector table plus scoreboard model for gate_event_logger.
module tb_gate_event_logger;
    logic        clk = 1'b0, rst = 1'b1, a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0, ev_ready = 1'b0;
    logic        ev_valid, overflow, mismatch;
    logic [7:0]  ev_data;
    logic [15:0] ev_count;
    int n_vec = 0, n_err = 0;

`ifdef GATE_CHECK_EN
    localparam bit MM_EXP = 1'b1;
`else
    localparam bit MM_EXP = 1'b0;
`endif

    gate_event_logger #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
        .ev_count(ev_count), .overflow(overflow), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    bit          m_run, m_pc, m_pd, m_ov, m_mm;
    logic [3:0]  m_ts;
    logic [15:0] m_cnt;
    logic [7:0]  sb[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit ci, input bit di, input bit rdy, input bit ai, input bit bi);
        bit pop, full;
        rst = r; c = ci; d = di; ev_ready = rdy; a = ai; b = bi;
        if (r) begin
            m_run = 0; m_pc = 0; m_pd = 0; m_ts = 0; m_cnt = 0; m_ov = 0; m_mm = 0;
            sb.delete();
        end else begin
            pop = sb.size() != 0 && rdy;
            full = sb.size() == 8;
`ifdef GATE_CHECK_EN
            if (m_run && (ci != (ai & bi) || di != (ai | bi))) m_mm = 1;
`endif
            if (pop) void'(sb.pop_front());
            if (!m_run) begin
                m_run = 1;
                m_ts = 0;
            end else if (ci != m_pc || di != m_pd) begin
                m_cnt++;
                if (full && !pop) m_ov = 1;
                else sb.push_back({m_ts, ci, di, ci ^ m_pc, di ^ m_pd});
                m_ts = 0;
            end else if (m_ts != 4'hF) m_ts++;
            m_pc = ci;
            m_pd = di;
        end
        @(posedge clk);
        #1;
        chk("ev_valid", ev_valid, sb.size() != 0);
        chk("ev_data", ev_data, sb.size() != 0 ? sb[0] : 8'h00);
        chk("ev_count", ev_count, m_cnt);
        chk("overflow", overflow, m_ov);
        chk("mismatch", mismatch, m_mm);
    endtask

    task automatic st(input bit r, input bit ci, input bit di, input bit rdy);
        cyc(r, ci, di, rdy, di, ci);
    endtask

    typedef struct {
        bit r, c, d, rdy;
        bit v;
        logic [7:0] dat;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        bit dv;
        int n;
        tbl = '{
            '{1, 0, 0, 0, 0, 8'h00, 16'd0},
            '{0, 0, 0, 0, 0, 8'h00, 16'd0},
            '{0, 0, 0, 0, 0, 8'h00, 16'd0},
            '{0, 0, 0, 0, 0, 8'h00, 16'd0},
            '{0, 0, 0, 0, 0, 8'h00, 16'd0},
            '{0, 0, 1, 0, 1, 8'h35, 16'd1},
            '{0, 0, 1, 1, 0, 8'h00, 16'd1},
            '{0, 0, 0, 0, 1, 8'h11, 16'd2},
            '{0, 1, 1, 0, 1, 8'h11, 16'd3},
            '{0, 1, 1, 1, 1, 8'h0F, 16'd3},
            '{0, 1, 1, 1, 0, 8'h00, 16'd3},
            '{0, 0, 0, 1, 1, 8'h23, 16'd4},
            '{0, 0, 0, 1, 0, 8'h00, 16'd4}
        };
        st(1, 0, 0, 0);
        repeat (20) st(0, 0, 0, 0);
        chk("idle_valid", ev_valid, 1'b0);
        chk("idle_count", ev_count, 16'd0);
        chk("idle_ovf", overflow, 1'b0);

        for (int i = 0; i < 13; i++) begin
            st(tbl[i].r, tbl[i].c, tbl[i].d, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), ev_valid, tbl[i].v);
            chk($sformatf("tbl%0d_data", i), ev_data, tbl[i].dat);
            chk($sformatf("tbl%0d_count", i), ev_count, tbl[i].cnt);
        end

        st(1, 0, 0, 0);
        st(0, 0, 0, 0);
        dv = 0;
        for (int i = 0; i < 9; i++) begin
            dv = ~dv;
            st(0, 0, dv, 0);
        end
        chk("fill_ovf", overflow, 1'b1);
        chk("fill_count", ev_count, 16'd9);
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", ev_valid, 1'b1);
            chk("drain_order", ev_data, (i % 2 == 0) ? 8'h05 : 8'h01);
            st(0, 0, dv, 1);
        end
        chk("drained_valid", ev_valid, 1'b0);

        st(1, 0, 0, 0);
        st(0, 0, 0, 0);
        dv = 0;
        for (int i = 0; i < 8; i++) begin
            dv = ~dv;
            st(0, 0, dv, 0);
        end
        chk("full_ovf", overflow, 1'b0);
        dv = ~dv;
        st(0, 0, dv, 1);
        chk("pushpop_ovf", overflow, 1'b0);
        chk("pushpop_count", ev_count, 16'd9);
        n = 0;
        while (ev_valid && n < 12) begin
            st(0, 0, dv, 1);
            n++;
        end
        chk("pushpop_depth", 16'(n), 16'd8);

        st(1, 0, 0, 0);
        st(0, 0, 0, 0);
        dv = 0;
        for (int i = 0; i < 9; i++) begin
            dv = ~dv;
            st(0, 0, dv, 0);
        end
        repeat (3) st(0, 0, dv, 1);
        chk("pre_rst_ovf", overflow, 1'b1);
        chk("pre_rst_valid", ev_valid, 1'b1);
        st(1, 0, dv, 0);
        chk("rst_valid", ev_valid, 1'b0);
        chk("rst_count", ev_count, 16'd0);
        chk("rst_ovf", overflow, 1'b0);
        st(0, 0, 1, 0);
        chk("init_count", ev_count, 16'd0);
        repeat (20) st(0, 0, 1, 0);
        chk("sat_count", ev_count, 16'd0);
        st(0, 0, 0, 0);
        chk("sat_data", ev_data, 8'hF1);
        st(0, 0, 0, 1);

        cyc(0, 1, 1, 0, 1, 0);
        chk("chk_set", mismatch, MM_EXP);
        cyc(0, 0, 1, 0, 1, 0);
        chk("chk_sticky", mismatch, MM_EXP);
        cyc(0, 0, 1, 1, 1, 0);
        chk("chk_sticky2", mismatch, MM_EXP);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
